matmul_batch_seq: RTL and testbench

MATMUL_BATCH_SEQ -- requirements
Module: matmul_batch_seq

---
 rtl/matmul_batch_seq.sv | 212 +++++++++++++++++++++
 tb/tb_matmul_batch_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/matmul_batch_seq.sv
// Sequential batched signed matrix multiplier: one MAC per cycle, IDLE -> CALC -> DONE handshake.
// Define MATMUL_BATCH_SAT_EN to saturate results to DATA_WIDTH; otherwise results wrap.
module matmul_batch_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int MATMUL_NUM = 4,
    parameter int SHAPE_M    = 4,
    parameter int SHAPE_K    = 4,
    parameter int SHAPE_N    = 4,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+$clog2(SHAPE_K)+1,
    parameter int OUT_SHIFT  = 0
) (
    input  logic                                                clk_p,
    input  logic                                                rst_n,
    input  logic                                                in_valid,
    output logic                                                in_ready,
    input  logic signed [DATA_WIDTH*MATMUL_NUM*SHAPE_M*SHAPE_K-1:0] matrix1,
    input  logic signed [DATA_WIDTH*MATMUL_NUM*SHAPE_K*SHAPE_N-1:0] matrix2,
    output logic                                                out_valid,
    input  logic                                                out_ready,
    output logic signed [DATA_WIDTH*MATMUL_NUM*SHAPE_M*SHAPE_N-1:0] mul,
    output logic                                                busy
);

    localparam int A_BITS = DATA_WIDTH*MATMUL_NUM*SHAPE_M*SHAPE_K;
    localparam int B_BITS = DATA_WIDTH*MATMUL_NUM*SHAPE_K*SHAPE_N;
    localparam int C_BITS = DATA_WIDTH*MATMUL_NUM*SHAPE_M*SHAPE_N;
    localparam int P_BITS = 2*DATA_WIDTH;

    localparam int BAT_W = (MATMUL_NUM > 1) ? $clog2(MATMUL_NUM) : 1;
    localparam int ROW_W = (SHAPE_M > 1) ? $clog2(SHAPE_M) : 1;
    localparam int COL_W = (SHAPE_N > 1) ? $clog2(SHAPE_N) : 1;
    localparam int K_W   = (SHAPE_K > 1) ? $clog2(SHAPE_K) : 1;

    localparam logic [BAT_W-1:0] BAT_LAST = BAT_W'(MATMUL_NUM-1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SHAPE_M-1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(SHAPE_N-1);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(SHAPE_K-1);

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic [DATA_WIDTH-1:0] reduce_width(input logic signed [ACC_WIDTH-1:0] v);
        logic [DATA_WIDTH-1:0] r;
`ifdef MATMUL_BATCH_SAT_EN
        if (v > SAT_MAX) begin
            r = SAT_MAX[DATA_WIDTH-1:0];
        end else if (v < SAT_MIN) begin
            r = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            r = v[DATA_WIDTH-1:0];
        end
`else
        r = v[DATA_WIDTH-1:0];
`endif
        return r;
    endfunction

    logic [1:0]                  state_r;
    logic [1:0]                  next_state_s;
    logic                        in_ready_r;
    logic                        out_valid_r;
    logic                        busy_r;
    logic [A_BITS-1:0]           a_r;
    logic [B_BITS-1:0]           b_r;
    logic [C_BITS-1:0]           mul_r;
    logic signed [ACC_WIDTH-1:0] acc_r;
    logic [BAT_W-1:0]            bat_r;
    logic [ROW_W-1:0]            row_r;
    logic [COL_W-1:0]            col_r;
    logic [K_W-1:0]              k_r;

    logic                         accept_s;
    logic                         last_k_s;
    logic                         last_s;
    logic [31:0]                  a_idx_s;
    logic [31:0]                  b_idx_s;
    logic [31:0]                  c_idx_s;
    logic signed [DATA_WIDTH-1:0] a_elem_s;
    logic signed [DATA_WIDTH-1:0] b_elem_s;
    logic signed [P_BITS-1:0]     prod_s;
    logic signed [ACC_WIDTH-1:0]  sum_s;
    logic signed [ACC_WIDTH-1:0]  shifted_s;
    logic [DATA_WIDTH-1:0]        res_s;

    // Handshake and loop-position decode
    always_comb begin
        accept_s = in_valid && in_ready_r && (state_r == ST_IDLE);
        last_k_s = (k_r == K_LAST);
        last_s   = last_k_s && (col_r == COL_LAST) && (row_r == ROW_LAST) && (bat_r == BAT_LAST);
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) next_state_s = ST_CALC;
                else          next_state_s = ST_IDLE;
            end
            ST_CALC: begin
                if (last_s) next_state_s = ST_DONE;
                else        next_state_s = ST_CALC;
            end
            ST_DONE: begin
                if (out_ready) next_state_s = ST_IDLE;
                else           next_state_s = ST_DONE;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // MAC datapath: operand select, multiply, accumulate, shift and reduce
    always_comb begin
        a_idx_s   = ((32'(bat_r)*SHAPE_M + 32'(row_r))*SHAPE_K + 32'(k_r))*DATA_WIDTH;
        b_idx_s   = ((32'(bat_r)*SHAPE_K + 32'(k_r))*SHAPE_N + 32'(col_r))*DATA_WIDTH;
        c_idx_s   = ((32'(bat_r)*SHAPE_M + 32'(row_r))*SHAPE_N + 32'(col_r))*DATA_WIDTH;
        a_elem_s  = a_r[a_idx_s +: DATA_WIDTH];
        b_elem_s  = b_r[b_idx_s +: DATA_WIDTH];
        prod_s    = P_BITS'(a_elem_s) * P_BITS'(b_elem_s);
        sum_s     = acc_r + ACC_WIDTH'(prod_s);
        shifted_s = sum_s >>> OUT_SHIFT;
        res_s     = reduce_width(shifted_s);
    end

    // State register; status flags are registered from the next state
    always_ff @(posedge clk_p) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            in_ready_r  <= (next_state_s == ST_IDLE);
            busy_r      <= (next_state_s == ST_CALC);
            out_valid_r <= (next_state_s == ST_DONE);
        end
    end

    // Loop counters, k fastest then column, row, batch
    always_ff @(posedge clk_p) begin
        if (!rst_n) begin
            k_r   <= '0;
            col_r <= '0;
            row_r <= '0;
            bat_r <= '0;
        end else if (accept_s) begin
            k_r   <= '0;
            col_r <= '0;
            row_r <= '0;
            bat_r <= '0;
        end else if (state_r == ST_CALC) begin
            if (!last_k_s) begin
                k_r <= k_r + K_W'(1);
            end else begin
                k_r <= '0;
                if (col_r != COL_LAST) begin
                    col_r <= col_r + COL_W'(1);
                end else begin
                    col_r <= '0;
                    if (row_r != ROW_LAST) begin
                        row_r <= row_r + ROW_W'(1);
                    end else begin
                        row_r <= '0;
                        if (bat_r != BAT_LAST) bat_r <= bat_r + BAT_W'(1);
                        else                   bat_r <= '0;
                    end
                end
            end
        end else begin
            k_r   <= k_r;
            col_r <= col_r;
            row_r <= row_r;
            bat_r <= bat_r;
        end
    end

    // Operand capture, accumulator and result storage
    always_ff @(posedge clk_p) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            acc_r <= '0;
            mul_r <= '0;
        end else if (accept_s) begin
            a_r   <= matrix1;
            b_r   <= matrix2;
            acc_r <= '0;
        end else if (state_r == ST_CALC) begin
            if (last_k_s) begin
                mul_r[c_idx_s +: DATA_WIDTH] <= res_s;
                acc_r <= '0;
            end else begin
                acc_r <= sum_s;
            end
        end else begin
            acc_r <= acc_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign mul       = mul_r;

endmodule

// File: tb/tb_matmul_batch_seq.sv
// Self-checking bench for matmul_batch_seq: directed and random batches against an arithmetic model.
module tb_matmul_batch_seq;

    logic clk_p = 1'b0;
    always #5 clk_p = ~clk_p;

    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [63:0] matrix1, matrix2, mul;
    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
    logic [31:0] s_matrix1, s_matrix2;
    logic [63:0] s_mul;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [63:0] C_A032 = 64'h0100_0001_0403_0201;
    localparam logic [63:0] C_B032 = 64'hFC03_02FF_0807_0605;
    localparam logic [63:0] C_M032 = 64'hFC03_02FF_322B_1613;
    localparam logic [63:0] C_ALL127 = 64'h7F7F_7F7F_7F7F_7F7F;
    localparam logic [63:0] C_ALLM128 = 64'h8080_8080_8080_8080;
`ifdef MATMUL_BATCH_SAT_EN
    localparam logic [63:0] C_M127 = 64'h7F7F_7F7F_7F7F_7F7F;
    localparam logic [63:0] C_MNEG = 64'h8080_8080_8080_8080;
`else
    localparam logic [63:0] C_M127 = 64'h0202_0202_0202_0202;
    localparam logic [63:0] C_MNEG = 64'h0000_0000_0000_0000;
`endif
    localparam logic [63:0] C_M034 = 64'hFEFE_FEFE_FEFE_FEFE;

    matmul_batch_seq #(
        .DATA_WIDTH(8), .MATMUL_NUM(2), .SHAPE_M(2), .SHAPE_K(2), .SHAPE_N(2), .OUT_SHIFT(0)
    ) u_dut (
        .clk_p(clk_p), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .matrix1(matrix1), .matrix2(matrix2), .out_valid(out_valid), .out_ready(out_ready),
        .mul(mul), .busy(busy)
    );

    matmul_batch_seq #(
        .DATA_WIDTH(8), .MATMUL_NUM(2), .SHAPE_M(2), .SHAPE_K(1), .SHAPE_N(2), .OUT_SHIFT(2)
    ) u_dut_shift (
        .clk_p(clk_p), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .matrix1(s_matrix1), .matrix2(s_matrix2), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .mul(s_mul), .busy(s_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer matrix products, floor shift, then saturate or wrap to 8 bits
    function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                            input int nb, input int m, input int kk,
                                            input int n, input int sh);
        logic [63:0]       res;
        longint            s;
        logic signed [7:0] ea, eb;
        res = 64'd0;
        for (int bb = 0; bb < nb; bb++) begin
            for (int r = 0; r < m; r++) begin
                for (int c = 0; c < n; c++) begin
                    s = 0;
                    for (int k = 0; k < kk; k++) begin
                        ea = a[((bb*m+r)*kk+k)*8 +: 8];
                        eb = b[((bb*kk+k)*n+c)*8 +: 8];
                        s = s + longint'(ea) * longint'(eb);
                    end
                    s = s >>> sh;
`ifdef MATMUL_BATCH_SAT_EN
                    if (s > 127) s = 127;
                    else if (s < -128) s = -128;
`endif
                    res[((bb*m+r)*n+c)*8 +: 8] = 8'(s);
                end
            end
        end
        return res;
    endfunction

    task automatic do_batch(input logic [63:0] a, input logic [63:0] b, input int hold);
        int          lat;
        logic [63:0] exp;
        exp = ref_mul(a, b, 2, 2, 2, 2, 0);
        lat = 0;
        while (in_ready !== 1'b1 && lat < 50) begin
            @(negedge clk_p);
            lat++;
        end
        chk("ready_before_accept", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        matrix1  = a;
        matrix2  = b;
        @(negedge clk_p);
        in_valid = 1'b0;
        matrix1  = {$urandom, $urandom};
        matrix2  = {$urandom, $urandom};
        chk("busy_in_calc", {62'd0, busy, in_ready}, 64'd2);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk_p);
            lat++;
        end
        chk("latency", 64'(lat), 64'd16);
        chk("done_flags", {62'd0, busy, in_ready}, 64'd0);
        chk("result", mul, exp);
        for (int i = 0; i < hold; i++) begin
            if (i == 2) begin
                in_valid = 1'b1;
                matrix1  = {$urandom, $urandom};
                matrix2  = {$urandom, $urandom};
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk_p);
            chk("hold_flags", {62'd0, out_valid, in_ready}, 64'd2);
            chk("hold_result", mul, exp);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk_p);
        out_ready = 1'b0;
        chk("after_handshake", {61'd0, out_valid, busy, in_ready}, 64'd1);
        chk("result_retained", mul, exp);
    endtask

    task automatic shift_batch(input logic [31:0] a, input logic [31:0] b);
        int          lat;
        logic [63:0] exp;
        exp = ref_mul({32'd0, a}, {32'd0, b}, 2, 2, 1, 2, 2);
        lat = 0;
        while (s_in_ready !== 1'b1 && lat < 50) begin
            @(negedge clk_p);
            lat++;
        end
        s_in_valid = 1'b1;
        s_matrix1  = a;
        s_matrix2  = b;
        @(negedge clk_p);
        s_in_valid = 1'b0;
        s_matrix1  = $urandom;
        s_matrix2  = $urandom;
        lat = 0;
        while (s_out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk_p);
            lat++;
        end
        chk("k1_latency", 64'(lat), 64'd8);
        chk("k1_result", s_mul, exp);
        s_out_ready = 1'b1;
        @(negedge clk_p);
        s_out_ready = 1'b0;
        chk("k1_after_handshake", {62'd0, s_out_valid, s_in_ready}, 64'd1);
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        matrix1     = 64'd0;
        matrix2     = 64'd0;
        s_in_valid  = 1'b0;
        s_out_ready = 1'b0;
        s_matrix1   = 32'd0;
        s_matrix2   = 32'd0;
        repeat (3) @(negedge clk_p);
        chk("reset_flags", {60'd0, in_ready, out_valid, busy, s_in_ready}, 64'd0);
        chk("reset_mul", mul, 64'd0);
        chk("reset_mul_k1", s_mul, 64'd0);
        rst_n = 1'b1;
        @(negedge clk_p);
        chk("ready_after_release", {62'd0, in_ready, s_in_ready}, 64'd3);

        do_batch(C_A032, C_B032, 0);
        chk("basic_const", mul, C_M032);

        do_batch(C_ALL127, C_ALL127, 0);
        chk("all127_const", mul, C_M127);
        do_batch(C_ALLM128, C_ALL127, 1);
        chk("neg_const", mul, C_MNEG);

        do_batch(C_A032, C_B032, 10);

        in_valid = 1'b1;
        matrix1  = {$urandom, $urandom};
        matrix2  = {$urandom, $urandom};
        @(negedge clk_p);
        in_valid = 1'b0;
        repeat (5) @(negedge clk_p);
        rst_n = 1'b0;
        @(negedge clk_p);
        chk("midcalc_reset_flags", {61'd0, in_ready, out_valid, busy}, 64'd0);
        chk("midcalc_reset_mul", mul, 64'd0);
        rst_n = 1'b1;
        @(negedge clk_p);
        chk("ready_after_abort", {61'd0, in_ready, out_valid, busy}, 64'd4);
        do_batch(C_A032, C_B032, 0);
        chk("post_abort_const", mul, C_M032);

        for (int i = 0; i < 6; i++) begin
            do_batch({$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(0, 3)));
        end

        shift_batch(32'h0101_0101, 32'hF9F9_F9F9);
        chk("shift_floor_const", s_mul, C_M034);
        for (int i = 0; i < 4; i++) begin
            shift_batch($urandom, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
